// File: rtl/multi_cycle_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and its datapath.
// slave = sequencer side, master = datapath/driver side.
interface multi_cycle_sequencer_if;
  logic        start;
  logic [5:0]  Opcode;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSource;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        RegWrite;
  logic        MemToReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        SignExtend;
  logic [3:0]  ALUOp;
  logic [3:0]  state;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] retired;

  modport slave (
    input  start, Opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, RegWrite, MemToReg, ALUSrcA, ALUSrcB, SignExtend, ALUOp,
           state, error, err_code, retired
  );

  modport master (
    output start, Opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, RegWrite, MemToReg, ALUSrcA, ALUSrcB, SignExtend, ALUOp,
           state, error, err_code, retired
  );
endinterface

// File: rtl/multi_cycle_sequencer.sv
// Moore sequencer for the shared multi-cycle MIPS datapath. One state per
// cycle, stalls in FETCH/MEMRD/MEMWR until mem_ready, traps illegal opcodes
// and memory timeouts into a sticky ERROR state, counts retired instructions.
module multi_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,  // 0 disables the timeout
  parameter int TW          = 5
) (
  input logic              clk,
  input logic              reset,
  multi_cycle_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC_R = 4'd7,
    S_RWB    = 4'd8,  S_EXEC_I = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_ERROR  = 4'd13
  } state_t;

  localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] retired_q, retired_d;
  logic        wait_st, timeout;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Ready in the last allowed cycle takes priority, hence the !mem_ready term.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == LAST_WAIT) && !bus.mem_ready;

  // State, wait counter, fault code and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_code_q <= 2'b00;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state: dispatch, memory stalls, faults and retirement.
  // The counter is zero in every non-wait state, so it is already clear on entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_code_d = err_code_q;
    retired_d  = retired_q;
    if (wait_st && !bus.mem_ready) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout) begin state_d = S_ERROR; err_code_d = 2'b10; end
      end
      S_DECODE: begin
        case (bus.Opcode) inside
          6'b000000:                state_d = S_EXEC_R;
          6'b100011, 6'b101011:     state_d = S_MEMADR;
          6'b000100:                state_d = S_BRANCH;
          6'b000010:                state_d = S_JUMP;
          [6'b001000:6'b001110]:    state_d = S_EXEC_I;
          default: begin state_d = S_ERROR; err_code_d = 2'b01; end
        endcase
      end
      S_MEMADR: state_d = (bus.Opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (timeout) begin state_d = S_ERROR; err_code_d = 2'b10; end
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin state_d = S_FETCH; retired_d = retired_q + 1; end
        else if (timeout) begin state_d = S_ERROR; err_code_d = 2'b10; end
      end
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 1;
      end
      S_ERROR:  state_d = S_ERROR;
      default: begin state_d = S_ERROR; err_code_d = 2'b01; end
    endcase
  end

  // Moore control decode; FETCH also forwards mem_ready to the IR/PC loads.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = 2'b00;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.SignExtend  = 1'b0;
    bus.ALUOp       = 4'b0000;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin bus.ALUSrcB = 2'b11; bus.SignExtend = 1'b1; end
      S_MEMADR: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.SignExtend = 1'b1; end
      S_MEMRD:  begin bus.MemRead = 1'b1; bus.IorD = 1'b1; end
      S_MEMWB:  begin bus.RegWrite = 1'b1; bus.MemToReg = 1'b1; end
      S_MEMWR:  begin bus.MemWrite = 1'b1; bus.IorD = 1'b1; end
      S_EXEC_R: begin bus.ALUSrcA = 1'b1; bus.ALUOp = 4'b0010; end
      S_RWB:    begin bus.RegWrite = 1'b1; bus.RegDst = 1'b1; end
      S_EXEC_I: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUOp      = {1'b1, bus.Opcode[2:0]};
        bus.SignExtend = ~bus.Opcode[2];   // andi/ori/xori zero-extend
      end
      S_IWB:    bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 4'b0001;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP:   begin bus.PCWrite = 1'b1; bus.PCSource = 2'b10; end
      default: ;
    endcase
  end

  assign bus.state    = state_q;
  assign bus.error    = (state_q == S_ERROR);
  assign bus.err_code = err_code_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Scoreboard bench: the stimulus process walks each instruction through its
// expected phases, pushing one expected record per cycle; the monitor pops
// and compares one record every falling edge.
module tb_multi_cycle_sequencer;
  localparam int TMO = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC_R = 7,
                 ST_RWB = 8, ST_EXEC_I = 9, ST_IWB = 10, ST_BRANCH = 11,
                 ST_JUMP = 12, ST_ERROR = 13;

  typedef struct packed {
    logic       PCWrite, PCWriteCond;
    logic [1:0] PCSource;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemToReg, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       SignExtend;
    logic [3:0] ALUOp;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        c;
    logic        err;
    logic [1:0]  code;
    logic [31:0] ret;
  } rec_t;

  logic clk, reset;
  multi_cycle_sequencer_if bus();

  multi_cycle_sequencer #(.MEM_TIMEOUT(TMO), .TW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  rec_t        q[$];
  int          checks = 0, errors = 0, ncyc = 0;
  logic [31:0] ret_m = 0;
  logic        err_m = 0;
  logic [1:0]  code_m = 0;

  // Control word each phase asserts, straight from the phase descriptions.
  function automatic ctl_t phase_ctl(int st, logic [5:0] op, logic rdy);
    ctl_t c = '0;
    case (st)
      ST_FETCH:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
      ST_DECODE: begin c.ALUSrcB = 2'b11; c.SignExtend = 1; end
      ST_MEMADR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.SignExtend = 1; end
      ST_MEMRD:  begin c.MemRead = 1; c.IorD = 1; end
      ST_MEMWB:  begin c.RegWrite = 1; c.MemToReg = 1; end
      ST_MEMWR:  begin c.MemWrite = 1; c.IorD = 1; end
      ST_EXEC_R: begin c.ALUSrcA = 1; c.ALUOp = 4'b0010; end
      ST_RWB:    begin c.RegWrite = 1; c.RegDst = 1; end
      ST_EXEC_I: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOp = {1'b1, op[2:0]};
                       c.SignExtend = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? 1'b0 : 1'b1; end
      ST_IWB:    c.RegWrite = 1;
      ST_BRANCH: begin c.ALUSrcA = 1; c.ALUOp = 4'b0001; c.PCWriteCond = 1; c.PCSource = 2'b01; end
      ST_JUMP:   begin c.PCWrite = 1; c.PCSource = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  // One clock of stimulus: drive inputs, push what the DUT must show this cycle.
  task automatic cyc(input int st, input logic rdy, input logic [5:0] op, input logic stv);
    rec_t r;
    bus.mem_ready = rdy;
    bus.Opcode    = op;
    bus.start     = stv;
    r.st   = st[3:0];
    r.c    = phase_ctl(st, op, rdy);
    r.err  = err_m;
    r.code = code_m;
    r.ret  = ret_m;
    q.push_back(r);
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ret_m = 0; err_m = 0; code_m = 0;
    cyc(ST_IDLE, rb(), 6'($urandom), rb());
    cyc(ST_IDLE, rb(), 6'($urandom), rb());
    reset = 1'b0;
    cyc(ST_IDLE, rb(), 6'($urandom), 1'b0);
    cyc(ST_IDLE, rb(), 6'($urandom), 1'b1);
  endtask

  // A wait state: dly not-ready cycles then ready, or a timeout into ERROR.
  task automatic mem_phase(input int st, input int dly, input logic [5:0] op, output bit to);
    to = 0;
    if (dly >= TMO) begin
      for (int k = 0; k < TMO; k++) cyc(st, 1'b0, op, rb());
      err_m = 1; code_m = 2'b10; to = 1;
    end else begin
      for (int k = 0; k < dly; k++) cyc(st, 1'b0, op, rb());
      cyc(st, 1'b1, op, rb());
    end
  endtask

  task automatic hold_error();
    for (int k = 0; k < 3; k++) cyc(ST_ERROR, rb(), 6'($urandom), rb());
  endtask

  // status: 0 retired, 1 faulted, 2 stopped in MEMRD for an external reset.
  task automatic run_instr(input logic [5:0] op, input int fdly, input int mdly,
                           input bit abort, output int status);
    bit to;
    status = 0;
    mem_phase(ST_FETCH, fdly, 6'($urandom), to);
    if (to) begin status = 1; return; end
    cyc(ST_DECODE, rb(), op, rb());
    if (op == 6'h00) begin
      cyc(ST_EXEC_R, rb(), op, rb()); cyc(ST_RWB, rb(), op, rb());
    end else if (op == 6'h23 || op == 6'h2B) begin
      cyc(ST_MEMADR, rb(), op, rb());
      if (op == 6'h23) begin
        if (abort) begin cyc(ST_MEMRD, 1'b0, op, rb()); status = 2; return; end
        mem_phase(ST_MEMRD, mdly, op, to);
        if (to) begin status = 1; return; end
        cyc(ST_MEMWB, rb(), op, rb());
      end else begin
        mem_phase(ST_MEMWR, mdly, op, to);
        if (to) begin status = 1; return; end
      end
    end else if (op == 6'h04) begin
      cyc(ST_BRANCH, rb(), op, rb());
    end else if (op == 6'h02) begin
      cyc(ST_JUMP, rb(), op, rb());
    end else if (op >= 6'h08 && op <= 6'h0E) begin
      cyc(ST_EXEC_I, rb(), op, rb()); cyc(ST_IWB, rb(), op, rb());
    end else begin
      err_m = 1; code_m = 2'b01; status = 1; return;
    end
    ret_m = ret_m + 1;
  endtask

  task automatic run_and_recover(input logic [5:0] op, input int fdly, input int mdly, input bit abort);
    int s;
    run_instr(op, fdly, mdly, abort, s);
    if (s == 1) begin hold_error(); do_reset(); end
    else if (s == 2) do_reset();
  endtask

  function automatic logic [5:0] rand_op();
    int p = $urandom_range(0, 19);
    if (p < 2)  return 6'h00;
    if (p < 5)  return 6'h23;
    if (p < 8)  return 6'h2B;
    if (p < 10) return 6'h04;
    if (p < 12) return 6'h02;
    if (p < 19) return 6'(8 + $urandom_range(0, 6));
    return 6'($urandom);
  endfunction

  function automatic int rand_dly();
    return ($urandom_range(0, 29) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    rec_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.st = bus.state;
      a.c  = '{bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
               bus.MemWrite, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.MemToReg,
               bus.ALUSrcA, bus.ALUSrcB, bus.SignExtend, bus.ALUOp};
      a.err  = bus.error;
      a.code = bus.err_code;
      a.ret  = bus.retired;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d got state=%0d ctl=%h err=%b code=%b ret=%0d want state=%0d ctl=%h err=%b code=%b ret=%0d",
                 ncyc, a.st, a.c, a.err, a.code, a.ret, e.st, e.c, e.err, e.code, e.ret);
      end
      ncyc++;
    end
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.Opcode = '0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    // directed: R, lw with 3-cycle stall, ori/addi, sw after late fetch, beq, j
    run_and_recover(6'h00, 0, 0, 0);
    run_and_recover(6'h23, 0, 3, 0);
    run_and_recover(6'h0D, 0, 0, 0);
    run_and_recover(6'h08, 0, 0, 0);
    run_and_recover(6'h2B, TMO - 1, 1, 0);
    run_and_recover(6'h04, 0, 0, 0);
    run_and_recover(6'h02, 1, 0, 0);
    // reset in the middle of a load
    run_and_recover(6'h23, 0, 0, 1);
    run_and_recover(6'h00, 0, 0, 0);
    // fetch timeout, memory timeout, illegal opcode
    run_and_recover(6'h00, TMO, 0, 0);
    run_and_recover(6'h23, 0, TMO, 0);
    run_and_recover(6'h3F, 0, 0, 0);
    run_and_recover(6'h0E, 2, 0, 0);
    // random program
    for (int i = 0; i < 150; i++)
      run_and_recover(rand_op(), rand_dly(), rand_dly(), $urandom_range(0, 39) == 0);
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending records want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
